mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rr.sv | 38 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and parameter defaults for the two-port memory arbiter
package mem_arb_pkg;

   localparam int DFLT_DATA_W    = 32;
   localparam int DFLT_MEM_WORDS = 2048;
   localparam int DFLT_RD_LAT    = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_LS = 1'b1
   } port_e;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - 2-way round-robin picker; pointer remembers the last granted port
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst_n,
   input  logic  i_req_if,
   input  logic  i_req_ls,
   input  logic  i_take,
   output logic  o_valid,
   output port_e o_port
);

   port_e last_q;
   port_e last_d;

   always_comb begin
      o_valid = i_req_if | i_req_ls;
      if (i_req_if && i_req_ls) begin
         o_port = (last_q == PORT_IF) ? PORT_LS : PORT_IF;
      end else if (i_req_ls) begin
         o_port = PORT_LS;
      end else begin
         o_port = PORT_IF;
      end
      last_d = (i_take && o_valid) ? o_port : last_q;
   end

   // Starting from IF means LS wins the first tie out of reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_q <= PORT_IF;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates IF and LS requests onto one registered memory port
// IDLE grants, ISSUE drives the memory for one cycle, WAIT covers read latency, RESP acks.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W    = DFLT_DATA_W,
   parameter int MEM_WORDS = DFLT_MEM_WORDS,
   parameter int RD_LAT    = DFLT_RD_LAT
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_if_req,
   input  logic [DATA_W-1:0] i_if_addr,
   output logic              o_if_ack,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_err,
   input  logic              i_ls_req,
   input  logic              i_ls_we,
   input  logic [DATA_W-1:0] i_ls_addr,
   input  logic [DATA_W-1:0] i_ls_wdata,
   output logic              o_ls_ack,
   output logic [DATA_W-1:0] o_ls_rdata,
   output logic              o_ls_err,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam logic [DATA_W-3:0] WORD_LIMIT = (DATA_W-2)'(MEM_WORDS);

   state_e            state_q;
   port_e             port_q;
   logic              we_q;
   logic              fault_q;
   logic [2:0]        cnt_q;
   logic              mem_we_q;
   logic [DATA_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              if_ack_q, if_err_q, ls_ack_q, ls_err_q;
   logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

   logic              gnt_valid;
   port_e             gnt_port;
   logic              take;
   logic              sel_we, sel_fault, to_resp, rd_ok;
   logic [DATA_W-1:0] sel_addr, sel_wdata;

   assign take = (state_q == IDLE);

   mem_arb_rr u_rr (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_req_if (i_if_req),
      .i_req_ls (i_ls_req),
      .i_take   (take),
      .o_valid  (gnt_valid),
      .o_port   (gnt_port)
   );

   always_comb begin
      sel_addr  = (gnt_port == PORT_LS) ? i_ls_addr : i_if_addr;
      sel_we    = (gnt_port == PORT_LS) && i_ls_we;
      sel_wdata = sel_we ? i_ls_wdata : '0;
      sel_fault = (sel_addr[1:0] != 2'b00) || (sel_addr[DATA_W-1:2] >= WORD_LIMIT);
      to_resp   = ((state_q == ISSUE) && (fault_q || we_q || (RD_LAT == 1)))
               || ((state_q == WAIT) && (cnt_q == 3'd0));
      rd_ok     = !we_q && !fault_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         port_q      <= PORT_IF;
         we_q        <= 1'b0;
         fault_q     <= 1'b0;
         cnt_q       <= 3'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         if_err_q    <= 1'b0;
         ls_ack_q    <= 1'b0;
         ls_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         if_err_q    <= 1'b0;
         ls_ack_q    <= 1'b0;
         ls_err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_valid) begin
                  state_q <= ISSUE;
                  port_q  <= gnt_port;
                  we_q    <= sel_we;
                  fault_q <= sel_fault;
                  // The memory port registers double as the latched request for ISSUE
                  if (!sel_fault) begin
                     mem_we_q    <= sel_we;
                     mem_addr_q  <= sel_addr;
                     mem_wdata_q <= sel_wdata;
                  end
               end
            end
            ISSUE: begin
               if (!to_resp) begin
                  state_q <= WAIT;
                  cnt_q   <= 3'(RD_LAT - 2);
               end
            end
            WAIT: begin
               if (!to_resp) begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               if (rd_ok) begin
                  if (port_q == PORT_IF) begin
                     if_rdata_q <= i_mem_rdata;
                  end else begin
                     ls_rdata_q <= i_mem_rdata;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
         if (to_resp) begin
            state_q <= RESP;
            if (port_q == PORT_IF) begin
               if_ack_q <= 1'b1;
               if_err_q <= fault_q;
            end else begin
               ls_ack_q <= 1'b1;
               ls_err_q <= fault_q;
            end
         end
      end
   end

   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_if_ack    = if_ack_q;
   assign o_if_err    = if_err_q;
   assign o_ls_ack    = ls_ack_q;
   assign o_ls_err    = ls_err_q;

   // Read data is only valid in the RESP cycle, so it bypasses the holding register then
   assign o_if_rdata  = (if_ack_q && rd_ok) ? i_mem_rdata : if_rdata_q;
   assign o_ls_rdata  = (ls_ack_q && rd_ok) ? i_mem_rdata : ls_rdata_q;

endmodule
